custom_instr_engine: RTL and testbench

//  Parametrised successor to the SELTEN custom-instruction unit: executes one custom op
//  (FFT/ENC/DEC/SPM/DWT/MAC/RNG plus CLR/LDM/RDM) per transaction on a private scratch memory.

---
 rtl/cie_pkg.sv | 27 ++
 rtl/cie_lfsr.sv | 33 +++
 rtl/custom_instr_engine.sv | 141 ++++++++++++++
 tb/tb_custom_instr_engine.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cie_pkg.sv
// Shared opcodes, FSM states and error-cause encoding for the custom instruction engine.
package cie_pkg;

  localparam logic [3:0] OP_FFT = 4'b0001;
  localparam logic [3:0] OP_ENC = 4'b0010;
  localparam logic [3:0] OP_DEC = 4'b0011;
  localparam logic [3:0] OP_SPM = 4'b0100;
  localparam logic [3:0] OP_DWT = 4'b0101;
  localparam logic [3:0] OP_MAC = 4'b0110;
  localparam logic [3:0] OP_RNG = 4'b0111;
  localparam logic [3:0] OP_CLR = 4'b1000;
  localparam logic [3:0] OP_LDM = 4'b1001;
  localparam logic [3:0] OP_RDM = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_OPCODE = 2'd1,
    ERR_ADDR   = 2'd2
  } err_cause_t;

endpackage

// File: rtl/cie_lfsr.sv
// Fibonacci-style LFSR for the RNG op; advances only when step is high.
// A zero seed would lock up the register, so it is replaced by 1.
module cie_lfsr #(
  parameter int unsigned W    = 19,
  parameter int unsigned SEED = 'h00001,
  parameter int unsigned TAPS = 'h40038
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] SEED_W = (W'(SEED) == '0) ? W'(1) : W'(SEED);
  localparam logic [W-1:0] TAPS_W = W'(TAPS);

  logic [W-1:0] lfsr_q;
  logic [W-1:0] lfsr_d;
  logic         fb;

  always_comb begin
    fb     = ^(lfsr_q & TAPS_W);
    lfsr_d = step ? {lfsr_q[W-2:0], fb} : lfsr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= SEED_W;
    else     lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q;

endmodule

// File: rtl/custom_instr_engine.sv
// One custom op per transaction on a private scratch memory: IDLE -> EXEC -> RESP.
// Memory read is launched on the accept edge so EXEC sees the data and commits the write.
module custom_instr_engine
  import cie_pkg::*;
#(
  parameter int unsigned W          = 19,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned FFT_OFFSET = 100,
  parameter int unsigned XOR_KEY    = 'h0FFFF,
  parameter int unsigned LFSR_SEED  = 'h00001,
  parameter int unsigned LFSR_TAPS  = 'h40038
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   opcode,
  input  logic [W-1:0] r1,
  input  logic [W-1:0] r2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [W-1:0] OFFSET_W = W'(FFT_OFFSET);
  localparam logic [W-1:0] KEY_W    = W'(XOR_KEY);

  state_t       state_q;
  logic         in_ready_q, out_valid_q, err_q;
  logic [W-1:0] result_q, acc_q, acc_d;
  logic [3:0]   op_q;
  logic [W-1:0] r1_q, r2_q, rd_q;
  logic [W-1:0] mem [DEPTH];

  logic [W-1:0] res_d, prod, lfsr_val;
  logic [AW-1:0] raddr;
  err_cause_t   cause_d;
  logic         accept, exec, need_a1, need_a2, does_wr, mem_we, lfsr_step;

  function automatic logic in_range(input logic [W-1:0] a);
    return (a >> AW) == '0;
  endfunction

  assign accept = in_valid && in_ready_q;
  assign exec   = (state_q == S_EXEC);
  assign raddr  = (opcode == OP_RDM) ? r1[AW-1:0] : r2[AW-1:0];
  assign prod   = r1_q * r2_q;

  cie_lfsr #(.W(W), .SEED(LFSR_SEED), .TAPS(LFSR_TAPS)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (lfsr_step),
    .value (lfsr_val)
  );

  always_comb begin
    res_d   = '0;
    acc_d   = acc_q;
    cause_d = ERR_NONE;
    need_a1 = 1'b0;
    need_a2 = 1'b0;
    does_wr = 1'b0;
    case (op_q)
      OP_FFT: begin res_d = rd_q + OFFSET_W; need_a1 = 1'b1; need_a2 = 1'b1; does_wr = 1'b1; end
      OP_ENC,
      OP_DEC: begin res_d = rd_q ^ KEY_W;    need_a1 = 1'b1; need_a2 = 1'b1; does_wr = 1'b1; end
      OP_SPM: begin res_d = rd_q;            need_a1 = 1'b1; need_a2 = 1'b1; does_wr = 1'b1; end
      OP_DWT: begin res_d = rd_q >> 1;       need_a1 = 1'b1; need_a2 = 1'b1; does_wr = 1'b1; end
      OP_MAC: begin acc_d = acc_q + prod; res_d = acc_d; end
      OP_RNG: begin res_d = lfsr_val;        need_a1 = 1'b1; does_wr = 1'b1; end
      OP_CLR: begin acc_d = '0; res_d = '0; end
      OP_LDM: begin res_d = r2_q;            need_a1 = 1'b1; does_wr = 1'b1; end
      OP_RDM: begin res_d = rd_q;            need_a1 = 1'b1; end
      default: cause_d = ERR_OPCODE;
    endcase
    if (cause_d == ERR_NONE && ((need_a1 && !in_range(r1_q)) || (need_a2 && !in_range(r2_q))))
      cause_d = ERR_ADDR;
    // Any error suppresses every side effect, including the LFSR step.
    if (cause_d != ERR_NONE) begin
      res_d = '0;
      acc_d = acc_q;
    end
  end

  assign mem_we    = exec && does_wr && (cause_d == ERR_NONE);
  assign lfsr_step = exec && (op_q == OP_RNG) && (cause_d == ERR_NONE);

  always_ff @(posedge clk) begin
    if (accept) rd_q <= mem[raddr];
    if (mem_we) mem[r1_q[AW-1:0]] <= res_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
      acc_q       <= '0;
      op_q        <= '0;
      r1_q        <= '0;
      r2_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          op_q       <= opcode;
          r1_q       <= r1;
          r2_q       <= r2;
          in_ready_q <= 1'b0;
          state_q    <= S_EXEC;
        end
        S_EXEC: begin
          result_q    <= res_d;
          err_q       <= (cause_d != ERR_NONE);
          acc_q       <= acc_d;
          out_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign err       = err_q;

endmodule

// File: tb/tb_custom_instr_engine.sv
// Bench for custom_instr_engine: vector table, randomized ops against a reference model,
// plus backpressure and mid-operation reset sequences.
module tb_custom_instr_engine;

  localparam int W     = 19;
  localparam int DEPTH = 256;
  localparam longint MOD  = longint'(1) << W;
  localparam longint TAPS = 'h40038;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, err;
  logic [3:0]   opcode;
  logic [W-1:0] r1, r2, result;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] mem_m [DEPTH];
  longint       acc_m;
  longint       lfsr_m;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         err;
  } vec_t;
  vec_t tbl[$];

  custom_instr_engine dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .r1        (r1),
    .r2        (r2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference behaviour written directly from the op table, using plain integer arithmetic.
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] res, output logic e);
    longint v, r;
    int unsigned ia, ib;
    ia = a; ib = b; r = 0; e = 1'b0; v = 0;
    case (op)
      1, 2, 3, 4, 5: begin
        if (ia >= DEPTH || ib >= DEPTH) e = 1'b1;
        else begin
          v = mem_m[ib];
          case (op)
            1:       r = (v + 100) % MOD;
            2, 3:    r = v ^ 'hFFFF;
            4:       r = v;
            default: r = v / 2;
          endcase
          mem_m[ia] = r[W-1:0];
        end
      end
      6: begin
        acc_m = (acc_m + (longint'(a) * longint'(b)) % MOD) % MOD;
        r = acc_m;
      end
      7: begin
        if (ia >= DEPTH) e = 1'b1;
        else begin
          r = lfsr_m;
          mem_m[ia] = r[W-1:0];
          lfsr_m = (lfsr_m * 2 + ($countones(lfsr_m & TAPS) % 2)) % MOD;
        end
      end
      8: begin acc_m = 0; r = 0; end
      9: begin
        if (ia >= DEPTH) e = 1'b1;
        else begin mem_m[ia] = b; r = b; end
      end
      10: begin
        if (ia >= DEPTH) e = 1'b1;
        else r = mem_m[ia];
      end
      default: e = 1'b1;
    endcase
    res = r[W-1:0];
  endtask

  task automatic exec_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] res, output logic e);
    int lat;
    lat = 0;
    @(negedge clk);
    in_valid = 1'b1; opcode = op; r1 = a; r2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) lat = 99;
    res = result;
    e   = err;
    chk("latency", lat, 2);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] dres, mres, a, b;
    logic         derr, merr, seen;
    logic [3:0]   op;
    int           k;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; opcode = '0; r1 = '0; r2 = '0;
    acc_m = 0; lfsr_m = 1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      exec_op(4'h9, W'(i), '0, dres, derr);
      model(4'h9, W'(i), '0, mres, merr);
    end

    tbl.push_back('{4'h7, 19'd1,       19'd0,     19'h00001, 1'b0});
    tbl.push_back('{4'h7, 19'd2,       19'd0,     19'h00002, 1'b0});
    tbl.push_back('{4'hA, 19'd1,       19'd0,     19'h00001, 1'b0});
    tbl.push_back('{4'h9, 19'd5,       19'h10,    19'h00010, 1'b0});
    tbl.push_back('{4'h1, 19'd6,       19'd5,     19'h00074, 1'b0});
    tbl.push_back('{4'hA, 19'd6,       19'd0,     19'h00074, 1'b0});
    tbl.push_back('{4'h2, 19'd7,       19'd5,     19'h0FFEF, 1'b0});
    tbl.push_back('{4'h3, 19'd8,       19'd7,     19'h00010, 1'b0});
    tbl.push_back('{4'h6, 19'd3,       19'd4,     19'd12,    1'b0});
    tbl.push_back('{4'h6, 19'd3,       19'd4,     19'd24,    1'b0});
    tbl.push_back('{4'h8, 19'd0,       19'd0,     19'd0,     1'b0});
    tbl.push_back('{4'h6, 19'h7FFFF,   19'd2,     19'h7FFFE, 1'b0});
    tbl.push_back('{4'hF, 19'd1,       19'd1,     19'd0,     1'b1});
    tbl.push_back('{4'h1, 19'd6,       19'h100,   19'd0,     1'b1});
    tbl.push_back('{4'hA, 19'd6,       19'd0,     19'h00074, 1'b0});
    tbl.push_back('{4'h4, 19'd9,       19'd6,     19'h00074, 1'b0});
    tbl.push_back('{4'hA, 19'd9,       19'd0,     19'h00074, 1'b0});
    tbl.push_back('{4'h5, 19'd10,      19'd9,     19'h0003A, 1'b0});
    tbl.push_back('{4'h1, 19'd10,      19'd10,    19'h0009E, 1'b0});
    tbl.push_back('{4'hA, 19'd10,      19'd0,     19'h0009E, 1'b0});
    tbl.push_back('{4'h9, 19'h100,     19'd5,     19'd0,     1'b1});
    tbl.push_back('{4'h0, 19'd0,       19'd0,     19'd0,     1'b1});
    tbl.push_back('{4'h7, 19'h200,     19'd0,     19'd0,     1'b1});
    tbl.push_back('{4'h7, 19'd3,       19'd0,     19'h00004, 1'b0});
    tbl.push_back('{4'hA, 19'd3,       19'd0,     19'h00004, 1'b0});
    tbl.push_back('{4'h6, 19'd1,       19'd2,     19'h00000, 1'b0});

    foreach (tbl[i]) begin
      exec_op(tbl[i].op, tbl[i].a, tbl[i].b, dres, derr);
      model(tbl[i].op, tbl[i].a, tbl[i].b, mres, merr);
      chk($sformatf("vec%0d_res", i), dres, tbl[i].res);
      chk($sformatf("vec%0d_err", i), derr, tbl[i].err);
    end

    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 11);
      op = (k >= 10) ? 4'($urandom_range(0, 15)) : 4'(k + 1);
      a = ($urandom_range(0, 9) == 0) ? W'($urandom_range(DEPTH, (1 << W) - 1)) : W'($urandom_range(0, 31));
      b = ($urandom_range(0, 9) == 0) ? W'($urandom_range(DEPTH, (1 << W) - 1)) : W'($urandom_range(0, 31));
      if (op == 4'h6) a = W'($urandom);
      if (op == 4'h6 || op == 4'h9) b = W'($urandom);
      exec_op(op, a, b, dres, derr);
      model(op, a, b, mres, merr);
      chk($sformatf("rnd%0d_op%0h_res", i, op), dres, mres);
      chk($sformatf("rnd%0d_op%0h_err", i, op), derr, merr);
    end

    // Backpressure: response held while a second command is offered and then withdrawn.
    @(negedge clk);
    in_valid = 1'b1; opcode = 4'h9; r1 = 19'd30; r2 = 19'h1234;
    @(posedge clk); #1;
    r1 = 19'd20; r2 = 19'd77;
    k = 0;
    while (k < 20 && !out_valid) begin @(negedge clk); k++; end
    chk("bp_resp_seen", out_valid, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_out_valid", c), out_valid, 1);
      chk($sformatf("bp%0d_result", c), result, 19'h1234);
      chk($sformatf("bp%0d_err", c), err, 0);
      chk($sformatf("bp%0d_in_ready", c), in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    model(4'h9, 19'd30, 19'h1234, mres, merr);
    seen = 1'b0;
    repeat (4) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    chk("bp_no_queued_resp", seen, 0);
    exec_op(4'hA, 19'd20, '0, dres, derr);
    model(4'hA, 19'd20, '0, mres, merr);
    chk("bp_ignored_write", dres, mres);
    exec_op(4'hA, 19'd30, '0, dres, derr);
    chk("bp_written", dres, 19'h1234);

    // Reset during EXEC of an LDM: no response, write lost, acc and lfsr back to reset.
    exec_op(4'h6, 19'd3, 19'd4, dres, derr);
    model(4'h6, 19'd3, 19'd4, mres, merr);
    chk("pre_rst_mac", dres, mres);
    @(negedge clk);
    in_valid = 1'b1; opcode = 4'h9; r1 = 19'd9; r2 = 19'h55;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_exec_in_ready", in_ready, 1);
    chk("rst_exec_out_valid", out_valid, 0);
    seen = 1'b0;
    repeat (4) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    chk("rst_exec_no_resp", seen, 0);
    acc_m = 0; lfsr_m = 1;
    exec_op(4'h6, 19'd0, 19'd0, dres, derr);
    chk("rst_acc_zero", dres, 0);
    exec_op(4'hA, 19'd9, '0, dres, derr);
    model(4'hA, 19'd9, '0, mres, merr);
    chk("rst_write_lost", dres, mres);
    exec_op(4'h7, 19'd11, '0, dres, derr);
    model(4'h7, 19'd11, '0, mres, merr);
    chk("rst_lfsr_seed", dres, 19'h00001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
